score_scan_ctrl: RTL and testbench
==================================

SCORE_SCAN_CTRL -- requirements
Module: score_scan_ctrl

Interface
REQ-001 Parameter READ_LAT, default 1: board-RAM read latency in cycles (legal range 1..2).
REQ-002 Parameter SCORE_W, default 16: score width, signed two's complement.
REQ-003 Port clk, input, 1: the single clock; all logic on rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port start, input, 1: evaluation request pulse.
REQ-006 Port checkmate, input, 2: nonzero means the side to move is mated.
REQ-007 Port stalemate, input, 1: position is stalemate.
REQ-008 Port white_to_move, input, 1: side to move, 1 = white.
REQ-009 Port sq_addr, output, 6: board-RAM read address {rank[2:0], file[2:0]}.
REQ-010 Port sq_rd, output, 1: board-RAM read strobe.
REQ-011 Port sq_data, input, 4: square contents, READ_LAT cycles after sq_rd; bit3 = colour (0 white, 1 black), bits[2:0] = type (0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king, 7 invalid).
REQ-012 Port busy, output, 1: evaluation in progress.
REQ-013 Port done, output, 1: one-cycle pulse; score valid.
REQ-014 Port score, output, SCORE_W: signed evaluation, white-positive, held until next done.

Function
REQ-015 FSM states SHALL be IDLE, CLASSIFY, SCAN, DRAIN, FINISH.
REQ-016 IDLE: start=1 SHALL latch checkmate, stalemate and white_to_move, then go to CLASSIFY with busy=1 next cycle.
REQ-017 CLASSIFY: latched checkmate!=0 SHALL set score to -MATE_SCORE if white_to_move else +MATE_SCORE, then go to FINISH; no RAM reads.
REQ-018 CLASSIFY: latched stalemate=1 with checkmate=0 SHALL set score to 0 and go to FINISH; checkmate has priority over stalemate.
REQ-019 CLASSIFY otherwise SHALL clear the accumulator and go to SCAN.
REQ-020 SCAN SHALL assert sq_rd with sq_addr 0,1,...,63 on 64 consecutive cycles, then go to DRAIN.
REQ-021 The returned data SHALL be accumulated: white pieces add value, black pieces subtract it.
REQ-022 Values SHALL be: pawn 1, knight 3, bishop 3, rook 5, queen 10; empty, king and invalid (type 7) contribute 0.
REQ-023 DRAIN SHALL last READ_LAT cycles, absorbing the outstanding reads, then load score from the accumulator and go to FINISH.
REQ-024 FINISH SHALL pulse done=1 for one cycle, drop busy, and return to IDLE.
REQ-025 Latency from the start cycle to done SHALL be 2 cycles for the terminal cases and 66+READ_LAT cycles for a scan.
REQ-026 start while busy=1 SHALL be ignored; start in the FINISH cycle SHALL be ignored.
REQ-027 Input changes after the start cycle SHALL have no effect on the current evaluation.
REQ-028 score SHALL update only in the done cycle; an intermediate accumulator SHALL never be visible on score.
REQ-029 sq_rd SHALL be 0 outside SCAN.

Reset
REQ-030 rst=1 SHALL force IDLE with busy=0, done=0, sq_rd=0, sq_addr=0, score=0 and accumulator=0.
REQ-031 Reset mid-scan SHALL abort without a done pulse; read data returning after reset SHALL be discarded.

Configuration
REQ-032 With SCORE_PAWN_ADV_EN defined, a white pawn on rank 6 and a black pawn on rank 1 (rank = sq_addr[5:3] of its read) SHALL each contribute 1 extra point in the owner's direction.
REQ-033 Without SCORE_PAWN_ADV_EN, only the REQ-022 values apply, and the rank pipeline register SHALL be absent.

Structure
REQ-034 Package chess_pkg SHALL hold the piece-type enum, COLOR_WHITE=0 and COLOR_BLACK=1, the piece-value table, and MATE_SCORE=16'sd32767.
REQ-035 Sub-module piece_value SHALL be a combinational lookup from the 4-bit square code to a signed contribution; the FSM, address counter and accumulator stay in score_scan_ctrl.

Verification
REQ-036 Standard start position, start pulse -> done at cycle 67 (READ_LAT=1), score=0, 64 sq_rd strobes with addresses 0..63.
REQ-037 Board holding only a white queen and a black rook -> score=+5; swap the colours -> score=-5.
REQ-038 checkmate=2'b01 and white_to_move=1 at start -> done 2 cycles later, score=-32767, no sq_rd; with white_to_move=0 -> +32767; checkmate plus stalemate -> mate score.
REQ-039 stalemate=1 -> score=0 in 2 cycles; start re-pulsed during a scan -> ignored, exactly one done.
REQ-040 rst asserted at scan address 30 -> next cycle busy=0 and score=0; no done pulse; a fresh start then gives the correct result.
REQ-041 Board with one white pawn at address 48: with SCORE_PAWN_ADV_EN, score=+2; without it, score=+1.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared chess encodings: piece types, colours, material values, mate score and scan FSM states.
package chess_pkg;

    typedef enum logic [2:0] {
        PcEmpty   = 3'd0,
        PcPawn    = 3'd1,
        PcKnight  = 3'd2,
        PcBishop  = 3'd3,
        PcRook    = 3'd4,
        PcQueen   = 3'd5,
        PcKing    = 3'd6,
        PcInvalid = 3'd7
    } piece_e;

    localparam logic COLOR_WHITE = 1'b0;
    localparam logic COLOR_BLACK = 1'b1;

    // Indexed by piece type; empty, king and invalid codes carry no material.
    localparam logic [7:0][3:0] PIECE_VALUE = {4'd0, 4'd0, 4'd10, 4'd5, 4'd3, 4'd3, 4'd1, 4'd0};

    localparam logic signed [15:0] MATE_SCORE = 16'sd32767;

    typedef enum logic [2:0] {
        StIdle,
        StClassify,
        StScan,
        StDrain,
        StFinish
    } scan_state_e;

endpackage

// File: rtl/piece_value.sv
// Combinational lookup from a 4-bit square code to its signed, white-positive material value.
module piece_value
    import chess_pkg::*;
(
    input  logic [3:0]        i_sq_code,
    output logic signed [4:0] o_value
);

    logic signed [4:0] w_mag;

    always_comb begin
        w_mag   = signed'({1'b0, PIECE_VALUE[i_sq_code[2:0]]});
        o_value = (i_sq_code[3] == COLOR_BLACK) ? -w_mag : w_mag;
    end

endmodule

// File: rtl/score_scan_ctrl.sv
// Position evaluator: classifies mate/stalemate or scans all 64 board squares summing material.
// Optional SCORE_PAWN_ADV_EN adds a point for pawns one step from promotion.
module score_scan_ctrl
    import chess_pkg::*;
#(
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned SCORE_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                checkmate,
    input  logic                      stalemate,
    input  logic                      white_to_move,
    output logic [5:0]                sq_addr,
    output logic                      sq_rd,
    input  logic [3:0]                sq_data,
    output logic                      busy,
    output logic                      done,
    output logic signed [SCORE_W-1:0] score
);

    localparam logic [1:0]                DRAIN_LAST = 2'(READ_LAT - 1);
    localparam logic signed [SCORE_W-1:0] MATE_POS   = SCORE_W'(MATE_SCORE);
    localparam logic signed [SCORE_W-1:0] MATE_NEG   = -MATE_POS;

    scan_state_e               r_state, w_state_next;
    logic                      r_mate, r_stale, r_white;
    logic [5:0]                r_addr;
    logic [1:0]                r_drain_cnt;
    logic [READ_LAT-1:0]       r_rd_pipe;
    logic signed [SCORE_W-1:0] r_acc, r_score, w_acc_next;
    logic signed [4:0]         w_piece, w_contrib;
    logic                      w_data_vld;

    piece_value u_piece_value (
        .i_sq_code (sq_data),
        .o_value   (w_piece)
    );

    // Top bit of the strobe pipeline marks the cycle sq_data belongs to an issued read.
    assign w_data_vld = r_rd_pipe[READ_LAT-1];

`ifdef SCORE_PAWN_ADV_EN
    logic [READ_LAT*3-1:0] r_rank_pipe;
    logic [2:0]            w_rank;
    logic                  w_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rank_pipe <= '0;
        end else begin
            r_rank_pipe <= (READ_LAT*3)'({r_rank_pipe, r_addr[5:3]});
        end
    end

    always_comb begin
        w_rank    = r_rank_pipe[READ_LAT*3-1 -: 3];
        w_adv     = (sq_data[2:0] == PcPawn) &&
                    ((sq_data[3] == COLOR_WHITE) ? (w_rank == 3'd6) : (w_rank == 3'd1));
        w_contrib = w_piece;
        if (w_adv) begin
            w_contrib = (sq_data[3] == COLOR_WHITE) ? w_piece + 5'sd1 : w_piece - 5'sd1;
        end
    end
`else
    assign w_contrib = w_piece;
`endif

    assign w_acc_next = w_data_vld ? r_acc + SCORE_W'(w_contrib) : r_acc;
    assign sq_addr    = r_addr;
    assign score      = r_score;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        sq_rd        = 1'b0;
        case (r_state)
            StIdle: begin
                if (start) w_state_next = StClassify;
            end
            StClassify: begin
                busy         = 1'b1;
                w_state_next = (r_mate || r_stale) ? StFinish : StScan;
            end
            StScan: begin
                busy  = 1'b1;
                sq_rd = 1'b1;
                if (r_addr == 6'd63) w_state_next = StDrain;
            end
            StDrain: begin
                busy = 1'b1;
                if (r_drain_cnt == DRAIN_LAST) w_state_next = StFinish;
            end
            StFinish: begin
                done         = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mate      <= 1'b0;
            r_stale     <= 1'b0;
            r_white     <= 1'b0;
            r_addr      <= '0;
            r_drain_cnt <= '0;
            r_rd_pipe   <= '0;
            r_acc       <= '0;
            r_score     <= '0;
        end else begin
            r_rd_pipe   <= READ_LAT'({r_rd_pipe, sq_rd});
            r_acc       <= w_acc_next;
            r_drain_cnt <= 2'd0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_mate  <= |checkmate;
                        r_stale <= stalemate;
                        r_white <= white_to_move;
                    end
                end
                StClassify: begin
                    if (r_mate) begin
                        r_score <= r_white ? MATE_NEG : MATE_POS;
                    end else if (r_stale) begin
                        r_score <= '0;
                    end else begin
                        r_acc <= '0;
                    end
                end
                StScan: r_addr <= r_addr + 6'd1;
                StDrain: begin
                    r_drain_cnt <= r_drain_cnt + 2'd1;
                    // Final read lands in the last drain cycle, so take the sum including it.
                    if (r_drain_cnt == DRAIN_LAST) r_score <= w_acc_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_score_scan_ctrl.sv
// Bench for score_scan_ctrl: cycle-level reference model plus directed evaluations.
module tb_score_scan_ctrl;

    localparam int RL = 1;
`ifdef SCORE_PAWN_ADV_EN
    localparam int PAWN_EXP = 2;
`else
    localparam int PAWN_EXP = 1;
`endif

    logic              clk;
    logic              rst;
    logic              start;
    logic [1:0]        checkmate;
    logic              stalemate;
    logic              white_to_move;
    logic [5:0]        sq_addr;
    logic              sq_rd;
    logic [3:0]        sq_data;
    logic              busy;
    logic              done;
    logic signed [15:0] score;

    score_scan_ctrl #(
        .READ_LAT (RL),
        .SCORE_W  (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .checkmate     (checkmate),
        .stalemate     (stalemate),
        .white_to_move (white_to_move),
        .sq_addr       (sq_addr),
        .sq_rd         (sq_rd),
        .sq_data       (sq_data),
        .busy          (busy),
        .done          (done),
        .score         (score)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int done_cnt = 0;

    logic [3:0] board [64];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Board RAM with one cycle of latency; non-read cycles return a white queen as bait.
    always @(posedge clk) sq_data <= sq_rd ? board[sq_addr] : 4'h5;

    always @(negedge clk) begin
        if (sq_rd) rd_cnt++;
        if (done) done_cnt++;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int board_score();
        int s = 0;
        for (int i = 0; i < 64; i++) begin
            int v;
            case (board[i][2:0])
                3'd1:       v = 1;
                3'd2, 3'd3: v = 3;
                3'd4:       v = 5;
                3'd5:       v = 10;
                default:    v = 0;
            endcase
`ifdef SCORE_PAWN_ADV_EN
            if (board[i][2:0] == 3'd1 &&
                ((!board[i][3] && i / 8 == 6) || (board[i][3] && i / 8 == 1))) v++;
`endif
            s += board[i][3] ? -v : v;
        end
        return s;
    endfunction

    // Reference model: an accepted start at cycle s owns cycles s..s+lat; done at s+lat.
    bit m_live = 0;
    bit m_active = 0;
    bit m_term = 0;
    int m_s = 0;
    int m_lat = 0;
    int m_result = 0;
    int m_score = 0;
    logic e_busy, e_done, e_rd;

    always @(negedge clk) begin
        if (rst) begin
            m_live   = 1;
            m_active = 0;
            m_score  = 0;
        end else if (m_live) begin
            e_busy = m_active && cyc > m_s && cyc < m_s + m_lat;
            e_done = m_active && cyc == m_s + m_lat;
            e_rd   = m_active && !m_term && cyc >= m_s + 2 && cyc <= m_s + 65;
            if (e_done) m_score = m_result;
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("sq_rd", sq_rd, e_rd);
            chk("score", score, m_score);
            if (e_rd) chk("sq_addr", sq_addr, cyc - m_s - 2);
            if (start && !m_active) begin
                m_active = 1;
                m_s      = cyc;
                m_term   = (checkmate != 2'b00) || stalemate;
                m_lat    = m_term ? 2 : 66 + RL;
                if (checkmate != 2'b00) m_result = white_to_move ? -32767 : 32767;
                else if (stalemate)     m_result = 0;
                else                    m_result = board_score();
            end else if (e_done) begin
                m_active = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_board();
        for (int i = 0; i < 64; i++) board[i] = 4'h0;
    endtask

    task automatic start_position();
        logic [2:0] back [8];
        back = '{3'd4, 3'd2, 3'd3, 3'd5, 3'd6, 3'd3, 3'd2, 3'd4};
        clear_board();
        for (int f = 0; f < 8; f++) begin
            board[f]      = {1'b0, back[f]};
            board[8 + f]  = 4'h1;
            board[48 + f] = 4'h9;
            board[56 + f] = {1'b1, back[f]};
        end
    endtask

    // Launch one evaluation, scramble the inputs, then check latency, score and strobe count.
    task automatic run_eval(input string name, input logic [1:0] cm, input logic st,
                            input logic wtm, input int exp_lat, input int exp_score,
                            input int exp_rds);
        int  n;
        bit  seen;
        checkmate     = cm;
        stalemate     = st;
        white_to_move = wtm;
        start         = 1'b1;
        rd_cnt        = 0;
        tick();
        start         = 1'b0;
        checkmate     = ~cm;
        stalemate     = ~st;
        white_to_move = ~wtm;
        seen = 0;
        for (n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk({name, "_done_seen"}, seen, 1);
        if (seen) begin
            chk({name, "_latency"}, n, exp_lat);
            chk({name, "_score"}, score, exp_score);
        end
        tick();
        chk({name, "_rd_count"}, rd_cnt, exp_rds);
        checkmate     = 2'b00;
        stalemate     = 1'b0;
        white_to_move = 1'b1;
    endtask

    initial begin
        int  n;
        bit  seen;
        rst           = 1'b1;
        start         = 1'b0;
        checkmate     = 2'b00;
        stalemate     = 1'b0;
        white_to_move = 1'b1;
        clear_board();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sq_rd", sq_rd, 0);
        chk("rst_sq_addr", sq_addr, 0);
        chk("rst_score", score, 0);
        tick();

        start_position();
        chk("model_start_pos", board_score(), 0);
        run_eval("start_pos", 2'b00, 1'b0, 1'b1, 66 + RL, 0, 64);

        // Kings and invalid codes are present to show they add nothing.
        clear_board();
        board[10] = 4'h5;
        board[50] = 4'hC;
        board[4]  = 4'h6;
        board[60] = 4'hE;
        board[20] = 4'h7;
        board[40] = 4'hF;
        chk("model_q_vs_r", board_score(), 5);
        run_eval("q_vs_r", 2'b00, 1'b0, 1'b0, 66 + RL, 5, 64);
        board[10] = 4'hD;
        board[50] = 4'h4;
        chk("model_r_vs_q", board_score(), -5);
        run_eval("r_vs_q", 2'b00, 1'b0, 1'b1, 66 + RL, -5, 64);

        run_eval("mate_white", 2'b01, 1'b0, 1'b1, 2, -32767, 0);
        run_eval("mate_black", 2'b01, 1'b0, 1'b0, 2, 32767, 0);
        run_eval("mate_and_stale", 2'b10, 1'b1, 1'b1, 2, -32767, 0);
        run_eval("stalemate", 2'b00, 1'b1, 1'b1, 2, 0, 0);

        // Re-pulse start mid-scan and again in the done cycle: exactly one done overall.
        done_cnt = 0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        seen  = 0;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk("repulse_done_seen", seen, 1);
        chk("repulse_score", score, -5);
        #1 start = 1'b1;
        tick();
        start = 1'b0;
        repeat (80) @(negedge clk);
        chk("repulse_done_count", done_cnt, 1);
        chk("repulse_idle", busy, 0);
        tick();

        // Reset while the scan is reading address 30.
        start = 1'b1;
        tick();
        start = 1'b0;
        seen  = 0;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (sq_rd && sq_addr == 6'd29) begin
                seen = 1;
                break;
            end
        end
        chk("abort_reached_29", seen, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        chk("abort_addr_at_rst", sq_addr, 30);
        tick();
        rst      = 1'b0;
        done_cnt = 0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_score", score, 0);
        repeat (10) @(negedge clk);
        chk("abort_no_done", done_cnt, 0);
        tick();
        run_eval("after_abort", 2'b00, 1'b0, 1'b1, 66 + RL, -5, 64);

        clear_board();
        board[48] = 4'h1;
        chk("model_pawn_w", board_score(), PAWN_EXP);
        run_eval("pawn_white_48", 2'b00, 1'b0, 1'b1, 66 + RL, PAWN_EXP, 64);
        board[48] = 4'h0;
        board[9]  = 4'h9;
        run_eval("pawn_black_9", 2'b00, 1'b0, 1'b0, 66 + RL, -PAWN_EXP, 64);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
